melody_sequencer: RTL and testbench



---
 rtl/melody_sequencer.sv | 177 +++++++++++++++++
 tb/tb_melody_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/melody_sequencer.sv
// Programmable (note, duration) melody table with a playback FSM that drives the
// note-select and enable inputs of the SPI sine-DAC player; lengths count in DIV-cycle ticks.
module melody_sequencer #(
  parameter  int unsigned CLK_FREQ  = 100000000,
  parameter  int unsigned TICK_HZ   = 1000,
  parameter  int unsigned DEPTH     = 32,
  parameter  int unsigned GAP_TICKS = 10,
  localparam int unsigned DIV       = CLK_FREQ / TICK_HZ,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          loop_en,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [15:0]   wr_data,
  output logic [5:0]    note_state,
  output logic          button_action,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] cur_index
);

  localparam int unsigned   PW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PSC_MAX = PW'(DIV - 1);
  localparam logic [9:0]    GAP_LEN = 10'(GAP_TICKS);
  localparam logic [AW-1:0] IDX_MAX = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_t;

  state_t        state_q;
  logic [15:0]   table_q [DEPTH];
  logic [15:0]   rd_q;
  logic [5:0]    note_q;
  logic          act_q;
  logic          busy_q;
  logic          done_q;
  logic [AW-1:0] idx_q;
  logic [PW-1:0] psc_q;
  logic [9:0]    dur_q;
  logic          armed_q;

  logic          tick_d;
  logic          seg_end_d;
  logic          loop_d;

  always_comb begin
    tick_d    = (psc_q == PSC_MAX);
    seg_end_d = tick_d && (dur_q == 10'd1);
    // A terminator at entry 0 must never loop, otherwise FETCH/LOAD would spin forever.
    loop_d    = loop_en && (idx_q != '0);
  end

  always_ff @(posedge clk) begin
    if (wr_en && (state_q == S_IDLE)) begin
      table_q[wr_addr] <= wr_data;
    end
    if (state_q == S_FETCH) begin
      rd_q <= table_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      note_q  <= '0;
      act_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
      psc_q   <= '0;
      dur_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      if (!start) begin
        armed_q <= 1'b1;
      end
      done_q <= 1'b0;

      if (stop && (state_q != S_IDLE)) begin
        state_q <= S_IDLE;
        note_q  <= '0;
        act_q   <= 1'b0;
        busy_q  <= 1'b0;
        idx_q   <= '0;
        psc_q   <= '0;
        dur_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start && !stop && armed_q) begin
              state_q <= S_FETCH;
              idx_q   <= '0;
              busy_q  <= 1'b1;
              armed_q <= 1'b0;
            end
          end

          S_FETCH: begin
            state_q <= S_LOAD;
          end

          S_LOAD: begin
            if (rd_q[9:0] == 10'd0) begin
              if (loop_d) begin
                idx_q   <= '0;
                state_q <= S_FETCH;
              end else begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
                note_q  <= '0;
                act_q   <= 1'b0;
              end
            end else begin
              note_q  <= rd_q[15:10];
              act_q   <= (rd_q[15:10] != 6'd0);
              dur_q   <= rd_q[9:0];
              psc_q   <= '0;
              state_q <= S_PLAY;
            end
          end

          S_PLAY, S_GAP: begin
            psc_q <= tick_d ? '0 : psc_q + 1'b1;
            if (tick_d) begin
              dur_q <= dur_q - 10'd1;
            end
            if (seg_end_d) begin
              act_q <= 1'b0;
              if ((state_q == S_PLAY) && (GAP_TICKS != 0)) begin
                state_q <= S_GAP;
                dur_q   <= GAP_LEN;
              end else if (idx_q != IDX_MAX) begin
                idx_q   <= idx_q + 1'b1;
                state_q <= S_FETCH;
              end else if (loop_d) begin
                idx_q   <= '0;
                state_q <= S_FETCH;
              end else begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
                note_q  <= '0;
              end
            end
          end

          S_DONE: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end

          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            act_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign note_state    = note_q;
  assign button_action = act_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign cur_index     = idx_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer: one instance with a 1-tick gap, one with no gap.
module tb_melody_sequencer;

  localparam int unsigned AW = 5;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          start   = 1'b0;
  logic          start0  = 1'b0;
  logic          stop    = 1'b0;
  logic          loop_en = 1'b0;
  logic          wr_en   = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [15:0]   wr_data = '0;

  logic [5:0]    note1, note0;
  logic          act1, act0, busy1, busy0, done1, done0;
  logic [AW-1:0] idx1, idx0;

  int n_chk = 0;
  int n_err = 0;

  int act_t  [2][400];
  int note_t [2][400];
  int done_t [2][400];
  int busy_t [2][400];
  int idx_t  [2][400];

  always #5 clk = ~clk;

  melody_sequencer #(
    .CLK_FREQ (8),
    .TICK_HZ  (1),
    .DEPTH    (32),
    .GAP_TICKS(1)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .loop_en      (loop_en),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .note_state   (note1),
    .button_action(act1),
    .busy         (busy1),
    .done         (done1),
    .cur_index    (idx1)
  );

  melody_sequencer #(
    .CLK_FREQ (8),
    .TICK_HZ  (1),
    .DEPTH    (32),
    .GAP_TICKS(0)
  ) u_dut0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start0),
    .stop         (stop),
    .loop_en      (loop_en),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .note_state   (note0),
    .button_action(act0),
    .busy         (busy0),
    .done         (done0),
    .cur_index    (idx0)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Sample k is taken on the falling edge after the k-th rising edge since the trigger.
  task automatic trace(input int from, input int n);
    for (int k = from; k < from + n; k++) begin
      @(negedge clk);
      act_t[1][k]  = int'(act1);
      note_t[1][k] = int'(note1);
      done_t[1][k] = int'(done1);
      busy_t[1][k] = int'(busy1);
      idx_t[1][k]  = int'(idx1);
      act_t[0][k]  = int'(act0);
      note_t[0][k] = int'(note0);
      done_t[0][k] = int'(done0);
      busy_t[0][k] = int'(busy0);
      idx_t[0][k]  = int'(idx0);
    end
  endtask

  task automatic wr(input int a, input int note, input int dur);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = {6'(note), 10'(dur)};
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  function automatic int cnt(input int sig, input int d, input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi; k++) begin
      case (sig)
        0:       c += act_t[d][k];
        1:       c += done_t[d][k];
        default: c += busy_t[d][k];
      endcase
    end
    return c;
  endfunction

  initial begin
    // Reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_note", int'(note1), 0);
    chk("rst_act",  int'(act1),  0);
    chk("rst_busy", int'(busy1), 0);
    chk("rst_done", int'(done1), 0);
    chk("rst_idx",  int'(idx1),  0);
    chk("rst_busy0", int'(busy0), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic two-note melody
    wr(0, 1, 2); wr(1, 3, 1); wr(2, 0, 0);
    start = 1'b1; trace(0, 1); start = 1'b0; trace(1, 60);
    chk("t1_act_k1",      act_t[1][1], 0);
    chk("t1_note1_len",   cnt(0, 1, 2, 17), 16);
    chk("t1_note_k2",     note_t[1][2], 1);
    chk("t1_act_k18",     act_t[1][18], 0);
    chk("t1_note_gap",    note_t[1][18], 1);
    chk("t1_silent_18_27", cnt(0, 1, 18, 27), 0);
    chk("t1_note2_len",   cnt(0, 1, 28, 35), 8);
    chk("t1_note_k28",    note_t[1][28], 3);
    chk("t1_idx_k28",     idx_t[1][28], 1);
    chk("t1_silent_tail", cnt(0, 1, 36, 60), 0);
    chk("t1_act_total",   cnt(0, 1, 0, 60), 24);
    chk("t1_done_k46",    done_t[1][46], 1);
    chk("t1_done_cnt",    cnt(1, 1, 0, 60), 1);
    chk("t1_busy_k46",    busy_t[1][46], 1);
    chk("t1_busy_k47",    busy_t[1][47], 0);
    chk("t1_note_done",   note_t[1][46], 0);

    // Rest entry between two notes
    wr(0, 2, 1); wr(1, 0, 3); wr(2, 5, 1); wr(3, 0, 0);
    start = 1'b1; trace(0, 1); start = 1'b0; trace(1, 89);
    chk("t2_note_k19",   note_t[1][19], 2);
    chk("t2_rest_note",  note_t[1][20], 0);
    chk("t2_rest_note2", note_t[1][43], 0);
    chk("t2_rest_idx",   idx_t[1][30], 1);
    chk("t2_silent",     cnt(0, 1, 10, 53), 0);
    chk("t2_note3",      note_t[1][54], 5);
    chk("t2_act_k54",    act_t[1][54], 1);
    chk("t2_act_total",  cnt(0, 1, 0, 89), 16);
    chk("t2_done_k72",   done_t[1][72], 1);
    chk("t2_busy_k73",   busy_t[1][73], 0);

    // Looping, then loop_en cleared during the second pass
    wr(0, 1, 1); wr(1, 2, 1); wr(2, 0, 0);
    loop_en = 1'b1;
    start = 1'b1; trace(0, 1); start = 1'b0; trace(1, 49);
    loop_en = 1'b0; trace(50, 40);
    chk("t3_idx_k36",   idx_t[1][36], 2);
    chk("t3_idx_wrap",  idx_t[1][38], 0);
    chk("t3_busy_wrap", busy_t[1][38], 1);
    chk("t3_no_done",   cnt(1, 1, 0, 49), 0);
    chk("t3_note_k40",  note_t[1][40], 1);
    chk("t3_act_k40",   act_t[1][40], 1);
    chk("t3_done_k76",  done_t[1][76], 1);
    chk("t3_done_cnt",  cnt(1, 1, 0, 89), 1);
    chk("t3_busy_k77",  busy_t[1][77], 0);
    chk("t3_act_total", cnt(0, 1, 0, 89), 32);

    // Stop in the 5th PLAY cycle, write attempt during PLAY
    wr(0, 4, 3); wr(1, 0, 0);
    start = 1'b1; trace(0, 1); start = 1'b0; trace(1, 3);
    wr_en = 1'b1; wr_addr = '0; wr_data = {6'd7, 10'd1};
    trace(4, 1);
    wr_en = 1'b0;
    trace(5, 2);
    stop = 1'b1; trace(7, 1); stop = 1'b0; trace(8, 30);
    chk("t4_act_k6",   act_t[1][6], 1);
    chk("t4_act_stop", act_t[1][7], 0);
    chk("t4_busy_stop", busy_t[1][7], 0);
    chk("t4_idx_stop", idx_t[1][7], 0);
    chk("t4_note_stop", note_t[1][7], 0);
    chk("t4_no_done",  cnt(1, 1, 0, 37), 0);
    start = 1'b1; trace(0, 1); start = 1'b0; trace(1, 44);
    chk("t4_entry_kept", note_t[1][2], 4);
    chk("t4_act_total",  cnt(0, 1, 0, 44), 24);
    chk("t4_done_k36",   done_t[1][36], 1);

    // Terminator at entry 0, start held high
    wr(0, 5, 0);
    start = 1'b1; trace(0, 10);
    chk("t5_done_k2",   done_t[1][2], 1);
    chk("t5_busy_k2",   busy_t[1][2], 1);
    chk("t5_note_k2",   note_t[1][2], 0);
    chk("t5_done_cnt",  cnt(1, 1, 0, 9), 1);
    chk("t5_no_act",    cnt(0, 1, 0, 9), 0);
    chk("t5_no_rerun",  cnt(2, 1, 3, 9), 0);
    start = 1'b0; trace(10, 1);
    start = 1'b1; trace(11, 2);
    chk("t5_rearm",     busy_t[1][11], 1);
    start = 1'b0; trace(13, 5);
    stop = 1'b1; start = 1'b1; trace(20, 3);
    chk("t5_stop_start", cnt(2, 1, 20, 22), 0);
    stop = 1'b0; start = 1'b0; trace(23, 2);

    // All entries dur=1 on the zero-gap instance
    for (int i = 0; i < 32; i++) wr(i, (i % 63) + 1, 1);
    start0 = 1'b1; trace(0, 1); start0 = 1'b0; trace(1, 330);
    chk("t6_act_k2",    act_t[0][2], 1);
    chk("t6_note_k2",   note_t[0][2], 1);
    chk("t6_act_fetch", act_t[0][10], 0);
    chk("t6_idx_k10",   idx_t[0][10], 1);
    chk("t6_idx_last",  idx_t[0][312], 31);
    chk("t6_note_last", note_t[0][312], 32);
    chk("t6_act_total", cnt(0, 0, 0, 330), 256);
    chk("t6_done_k320", done_t[0][320], 1);
    chk("t6_done_cnt",  cnt(1, 0, 0, 330), 1);
    chk("t6_busy_k321", busy_t[0][321], 0);

    // Reset mid-note
    start0 = 1'b1; trace(0, 1); start0 = 1'b0; trace(1, 13);
    chk("t7_act_pre", act_t[0][13], 1);
    chk("t7_idx_pre", idx_t[0][13], 1);
    rst_n = 1'b0; trace(14, 1);
    chk("t7_note", note_t[0][14], 0);
    chk("t7_act",  act_t[0][14],  0);
    chk("t7_busy", busy_t[0][14], 0);
    chk("t7_done", done_t[0][14], 0);
    chk("t7_idx",  idx_t[0][14],  0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
